// File: rtl/vliw_pipe_stage_if.sv
// rtl/vliw_pipe_stage_if.sv - bundle handshake and status signals of the VLIW pipe stage
interface vliw_pipe_stage_if #(
  parameter int SLOTS  = 2,
  parameter int SLOT_W = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic [SLOTS*SLOT_W-1:0] in_data;
  logic [SLOTS-1:0]        in_slot_en;
  logic                    out_valid;
  logic                    out_ready;
  logic [SLOTS*SLOT_W-1:0] out_data;
  logic [SLOTS-1:0]        out_slot_en;
  logic [1:0]              occupancy;
  logic [15:0]             bundle_count;

  // master: the surrounding pipeline; slave: the stage itself
  modport master (
    output in_valid, in_data, in_slot_en, out_ready,
    input  in_ready, out_valid, out_data, out_slot_en, occupancy, bundle_count
  );

  modport slave (
    input  in_valid, in_data, in_slot_en, out_ready,
    output in_ready, out_valid, out_data, out_slot_en, occupancy, bundle_count
  );
endinterface

// File: rtl/vliw_pipe_stage.sv
// rtl/vliw_pipe_stage.sv - two-entry registered VLIW bundle stage with NOP drop and flush
module vliw_pipe_stage #(
  parameter int SLOTS    = 2,
  parameter int SLOT_W   = 16,
  parameter int DROP_NOP = 1
) (
  input logic              clk,
  input logic              reset,
  input logic              flush,
  vliw_pipe_stage_if.slave bus
);
  localparam int W = SLOTS * SLOT_W;

  logic [W-1:0]     mem_data [2];
  logic [SLOTS-1:0] mem_en   [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic [15:0]      delivered;
  logic             push_hs;
  logic             is_nop;
  logic             do_push;
  logic             do_pop;

  assign bus.in_ready  = (count != 2'd2) && !flush && !reset;
  assign bus.out_valid = (count != 2'd0) && !flush;

  // An all-disabled bundle still completes its handshake; it just never lands in storage.
  assign push_hs = bus.in_valid && bus.in_ready;
  assign is_nop  = (DROP_NOP != 0) && (bus.in_slot_en == '0);
  assign do_push = push_hs && !is_nop;
  assign do_pop  = bus.out_valid && bus.out_ready;

  assign bus.out_slot_en  = bus.out_valid ? mem_en[rd_ptr] : '0;
  assign bus.occupancy    = count;
  assign bus.bundle_count = delivered;

  // Disabled slots read as zero so downstream sees the canonical NOP encoding.
  for (genvar k = 0; k < SLOTS; k++) begin : g_slot
    assign bus.out_data[k*SLOT_W +: SLOT_W] =
      bus.out_slot_en[k] ? mem_data[rd_ptr][k*SLOT_W +: SLOT_W] : '0;
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_data[wr_ptr] <= bus.in_data;
      mem_en[wr_ptr]   <= bus.in_slot_en;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
      delivered <= 16'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop) begin
        rd_ptr    <= ~rd_ptr;
        delivered <= delivered + 16'd1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_vliw_pipe_stage.sv
// tb/tb_vliw_pipe_stage.sv - self-checking bench for vliw_pipe_stage
module tb_vliw_pipe_stage;
  logic clk;
  logic reset;
  logic flush1;
  logic flush0;
  logic flush_s1;

  int errors = 0;
  int checks = 0;

  vliw_pipe_stage_if #(.SLOTS(2), .SLOT_W(16)) bus1();
  vliw_pipe_stage_if #(.SLOTS(2), .SLOT_W(16)) bus0();
  vliw_pipe_stage_if #(.SLOTS(1), .SLOT_W(8))  bus_s1();

  vliw_pipe_stage #(.SLOTS(2), .SLOT_W(16), .DROP_NOP(1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush1), .bus(bus1));
  vliw_pipe_stage #(.SLOTS(2), .SLOT_W(16), .DROP_NOP(0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush0), .bus(bus0));
  vliw_pipe_stage #(.SLOTS(1), .SLOT_W(8), .DROP_NOP(1)) dut_s1 (
    .clk(clk), .reset(reset), .flush(flush_s1), .bus(bus_s1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic [1:0]  en;
    logic        ordy;
    logic        fl;
    logic        rdy;
    logic        ov;
    logic [1:0]  occ;
    logic [15:0] cnt;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  en;
  } exp_t;

  vec_t tv[$];
  exp_t sb[$];

  function automatic vec_t mk(logic v, logic [31:0] d, logic [1:0] en, logic ordy, logic fl,
                              logic rdy, logic ov, logic [1:0] occ, logic [15:0] cnt);
    vec_t t;
    t.v = v; t.d = d; t.en = en; t.ordy = ordy; t.fl = fl;
    t.rdy = rdy; t.ov = ov; t.occ = occ; t.cnt = cnt;
    return t;
  endfunction

  function automatic logic [31:0] masked(logic [31:0] d, logic [1:0] en);
    return {en[1] ? d[31:16] : 16'h0, en[0] ? d[15:0] : 16'h0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t t, input int idx);
    exp_t e;
    @(negedge clk);
    bus1.in_valid   = t.v;
    bus1.in_data    = t.d;
    bus1.in_slot_en = t.en;
    bus1.out_ready  = t.ordy;
    flush1          = t.fl;
    #1;
    chk($sformatf("v%0d in_ready", idx), {63'd0, bus1.in_ready}, {63'd0, t.rdy});
    chk($sformatf("v%0d out_valid", idx), {63'd0, bus1.out_valid}, {63'd0, t.ov});
    chk($sformatf("v%0d occupancy", idx), {62'd0, bus1.occupancy}, {62'd0, t.occ});
    chk($sformatf("v%0d bundle_count", idx), {48'd0, bus1.bundle_count}, {48'd0, t.cnt});
    if (t.ov) begin
      chk($sformatf("v%0d sb_nonempty", idx), {63'd0, sb.size() != 0}, 64'd1);
      if (sb.size() != 0) begin
        e = t.ordy ? sb.pop_front() : sb[0];
        chk($sformatf("v%0d out_data", idx), {32'd0, bus1.out_data}, {32'd0, e.d});
        chk($sformatf("v%0d out_slot_en", idx), {62'd0, bus1.out_slot_en}, {62'd0, e.en});
      end
    end else begin
      chk($sformatf("v%0d idle_data", idx), {32'd0, bus1.out_data}, 64'd0);
      chk($sformatf("v%0d idle_en", idx), {62'd0, bus1.out_slot_en}, 64'd0);
    end
    if (t.fl) sb.delete();
    else if (t.v && t.rdy && t.en != 2'b00) begin
      e.d  = masked(t.d, t.en);
      e.en = t.en;
      sb.push_back(e);
    end
  endtask

  initial begin
    tv.push_back(mk(1'b0, 32'h0,        2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 16'd0));
    tv.push_back(mk(1'b1, 32'h1234ABCD, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 16'd0));
    tv.push_back(mk(1'b0, 32'h0,        2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 16'd0));
    tv.push_back(mk(1'b0, 32'h0,        2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 16'd1));
    // backpressure: A,B stored, C held until space frees
    tv.push_back(mk(1'b1, 32'hAAAA0001, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'd1));
    tv.push_back(mk(1'b1, 32'hBBBB0002, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 16'd1));
    tv.push_back(mk(1'b1, 32'hCCCC0003, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 16'd1));
    tv.push_back(mk(1'b1, 32'hCCCC0003, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 16'd1));
    tv.push_back(mk(1'b1, 32'hCCCC0003, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 16'd1));
    tv.push_back(mk(1'b1, 32'hCCCC0003, 2'd3, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 16'd2));
    tv.push_back(mk(1'b0, 32'h0,        2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 16'd3));
    tv.push_back(mk(1'b0, 32'h0,        2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 16'd4));
    // NOP drop
    tv.push_back(mk(1'b1, 32'hFFFFFFFF, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 16'd4));
    tv.push_back(mk(1'b1, 32'hDEAD0007, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 16'd4));
    tv.push_back(mk(1'b0, 32'h0,        2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 16'd4));
    tv.push_back(mk(1'b0, 32'h0,        2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 16'd5));
    // flush at full occupancy with incoming valid
    tv.push_back(mk(1'b1, 32'hD0D0D0D0, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'd5));
    tv.push_back(mk(1'b1, 32'hE0E0E0E0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 16'd5));
    tv.push_back(mk(1'b1, 32'hF0F0F0F0, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 16'd5));
    tv.push_back(mk(1'b0, 32'h0,        2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 16'd5));
    // streaming: simultaneous push and pop at occupancy 1
    tv.push_back(mk(1'b1, 32'h11112222, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 16'd5));
    tv.push_back(mk(1'b1, 32'h33334444, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 16'd5));
    tv.push_back(mk(1'b0, 32'h0,        2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 16'd6));
    tv.push_back(mk(1'b0, 32'h0,        2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 16'd7));
    // fill to 2 for the async reset case
    tv.push_back(mk(1'b1, 32'h55556666, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'd7));
    tv.push_back(mk(1'b1, 32'h77778888, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 16'd7));
    tv.push_back(mk(1'b0, 32'h0,        2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 16'd7));

    reset = 1'b1;
    flush1 = 1'b0; flush0 = 1'b0; flush_s1 = 1'b0;
    bus1.in_valid = 1'b1; bus1.in_data = 32'h12345678; bus1.in_slot_en = 2'b11; bus1.out_ready = 1'b1;
    bus0.in_valid = 1'b0; bus0.in_data = 32'h0; bus0.in_slot_en = 2'b00; bus0.out_ready = 1'b0;
    bus_s1.in_valid = 1'b0; bus_s1.in_data = 8'h0; bus_s1.in_slot_en = 1'b0; bus_s1.out_ready = 1'b0;

    #12;
    chk("rst in_ready", {63'd0, bus1.in_ready}, 64'd0);
    chk("rst out_valid", {63'd0, bus1.out_valid}, 64'd0);
    chk("rst occupancy", {62'd0, bus1.occupancy}, 64'd0);
    chk("rst bundle_count", {48'd0, bus1.bundle_count}, 64'd0);
    chk("rst out_data", {32'd0, bus1.out_data}, 64'd0);
    chk("rst out_slot_en", {62'd0, bus1.out_slot_en}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    bus1.in_valid = 1'b0;
    #1;
    chk("post_rst in_ready", {63'd0, bus1.in_ready}, 64'd1);

    foreach (tv[i]) apply(tv[i], i);

    // async reset between edges while holding two bundles
    #2;
    reset = 1'b1;
    #1;
    chk("arst out_valid", {63'd0, bus1.out_valid}, 64'd0);
    chk("arst in_ready", {63'd0, bus1.in_ready}, 64'd0);
    chk("arst occupancy", {62'd0, bus1.occupancy}, 64'd0);
    chk("arst out_data", {32'd0, bus1.out_data}, 64'd0);
    chk("arst out_slot_en", {62'd0, bus1.out_slot_en}, 64'd0);
    chk("arst bundle_count", {48'd0, bus1.bundle_count}, 64'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    bus1.in_valid = 1'b1; bus1.in_data = 32'h9999AAAA; bus1.in_slot_en = 2'b11; bus1.out_ready = 1'b1;
    #1;
    chk("arst_rel in_ready", {63'd0, bus1.in_ready}, 64'd1);
    chk("arst_rel occupancy", {62'd0, bus1.occupancy}, 64'd0);
    @(negedge clk);
    bus1.in_valid = 1'b0;
    #1;
    chk("first_accept out_valid", {63'd0, bus1.out_valid}, 64'd1);
    chk("first_accept out_data", {32'd0, bus1.out_data}, 64'h9999AAAA);

    // DROP_NOP=0 instance keeps the all-disabled bundle
    @(negedge clk);
    bus0.in_valid = 1'b1; bus0.in_data = 32'hFFFFFFFF; bus0.in_slot_en = 2'b00; bus0.out_ready = 1'b0;
    @(negedge clk);
    bus0.in_data = 32'hDEAD0007; bus0.in_slot_en = 2'b01;
    @(negedge clk);
    bus0.in_valid = 1'b0;
    #1;
    chk("keep occupancy", {62'd0, bus0.occupancy}, 64'd2);
    chk("keep nop out_valid", {63'd0, bus0.out_valid}, 64'd1);
    chk("keep nop out_slot_en", {62'd0, bus0.out_slot_en}, 64'd0);
    chk("keep nop out_data", {32'd0, bus0.out_data}, 64'd0);
    bus0.out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("keep second out_slot_en", {62'd0, bus0.out_slot_en}, 64'd1);
    chk("keep second out_data", {32'd0, bus0.out_data}, 64'h00000007);
    chk("keep count1", {48'd0, bus0.bundle_count}, 64'd1);
    @(negedge clk);
    #1;
    chk("keep drained", {62'd0, bus0.occupancy}, 64'd0);
    chk("keep count2", {48'd0, bus0.bundle_count}, 64'd2);
    bus0.out_ready = 1'b0;

    // bundle_count wrap: one pop already done, stream 65534 more
    @(negedge clk);
    bus1.in_valid = 1'b1; bus1.in_data = 32'h00000001; bus1.in_slot_en = 2'b01; bus1.out_ready = 1'b1;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    bus1.in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("pre_wrap count", {48'd0, bus1.bundle_count}, 64'hFFFF);
    chk("pre_wrap occupancy", {62'd0, bus1.occupancy}, 64'd0);
    bus1.in_valid = 1'b1;
    @(negedge clk);
    bus1.in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("wrap count", {48'd0, bus1.bundle_count}, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
